video_timing_480p: RTL and testbench

Pixel-clock-domain video timing generator for the 720x480p60 output path, clocked by the 27 MHz PLL output. It waits for the PLL `locked` flag and a settle delay, then drives sync, data-enable and a one-cycle-ahead pixel request to the framebuffer reader. It re-registers the returned RGB so that RGB, sync and DE leave the block aligned for the HDMI transmitter.

---
 rtl/video_timing_480p.sv | 178 +++++++++++++++++
 tb/tb_video_timing_480p.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_480p.sv
// 720x480p60 video timing generator: lock bring-up, sync/DE generation,
// one-cycle-ahead pixel request and RGB re-registration for the HDMI path.
module video_timing_480p #(
    parameter int H_ACTIVE      = 720,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 62,
    parameter int H_BP          = 60,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 9,
    parameter int V_SYNC        = 6,
    parameter int V_BP          = 30,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pll_locked,
    output logic        pixel_req,
    output logic [9:0]  req_x,
    output logic [9:0]  req_y,
    input  logic [23:0] pix_rgb,
    output logic        frame_start,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic [23:0] rgb_out,
    output logic        running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST =
        CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          lock_meta;
    logic          locked_s;
    logic [CW-1:0] settle_cnt;

    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       run_nxt;
    logic       act_nxt;
    logic       hs_nxt;
    logic       vs_nxt;
    logic       fs_nxt;

    logic hs0;
    logic vs0;
    logic de1;
    logic hs1;
    logic vs1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta <= 1'b0;
            locked_s  <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            locked_s  <= lock_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == SETTLE && state_next == SETTLE)
                settle_cnt <= settle_cnt + 1'b1;
            else
                settle_cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            WAIT_LOCK: begin
                if (locked_s)
                    state_next = (SETTLE_CYCLES == 0) ? RUN : SETTLE;
            end
            SETTLE: begin
                if (!locked_s)
                    state_next = WAIT_LOCK;
                else if (settle_cnt == SETTLE_LAST)
                    state_next = RUN;
            end
            RUN: begin
                if (!locked_s)
                    state_next = WAIT_LOCK;
            end
            default: state_next = WAIT_LOCK;
        endcase
    end

    // Decode the position that will be presented after the coming edge,
    // so every output can be registered.
    always_comb begin
        run_nxt = (state_next == RUN);
        h_nxt   = '0;
        v_nxt   = '0;
        if (state == RUN) begin
            if (h == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h_nxt = h + 1'b1;
                v_nxt = v;
            end
        end
        act_nxt = run_nxt && (h_nxt < H_ACT) && (v_nxt < V_ACT);
        hs_nxt  = !(run_nxt && (h_nxt >= HS_BEG) && (h_nxt < HS_END));
        vs_nxt  = !(run_nxt && (v_nxt >= VS_BEG) && (v_nxt < VS_END));
        fs_nxt  = run_nxt && (h_nxt == '0) && (v_nxt == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h           <= '0;
            v           <= '0;
            pixel_req   <= 1'b0;
            req_x       <= '0;
            req_y       <= '0;
            frame_start <= 1'b0;
            running     <= 1'b0;
            hs0         <= 1'b1;
            vs0         <= 1'b1;
            de1         <= 1'b0;
            hs1         <= 1'b1;
            vs1         <= 1'b1;
            de          <= 1'b0;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            rgb_out     <= '0;
        end else begin
            h           <= run_nxt ? h_nxt : '0;
            v           <= run_nxt ? v_nxt : '0;
            pixel_req   <= act_nxt;
            req_x       <= act_nxt ? h_nxt : '0;
            req_y       <= act_nxt ? v_nxt : '0;
            frame_start <= fs_nxt;
            running     <= run_nxt;
            hs0         <= hs_nxt;
            vs0         <= vs_nxt;
            // Leaving RUN kills the in-flight request so DE drops one
            // cycle after pixel_req.
            de1         <= run_nxt && pixel_req;
            hs1         <= run_nxt ? hs0 : 1'b1;
            vs1         <= run_nxt ? vs0 : 1'b1;
            de          <= de1;
            hsync_n     <= hs1;
            vsync_n     <= vs1;
            rgb_out     <= de1 ? pix_rgb : '0;
        end
    end

endmodule

// File: tb/tb_video_timing_480p.sv
// Scoreboard bench for video_timing_480p on a shrunken raster, with
// randomized lock drops checked against an arithmetic timing model.
module tb_video_timing_480p;

    localparam int HA  = 20;
    localparam int HFP = 3;
    localparam int HS  = 4;
    localparam int HBP = 5;
    localparam int VA  = 10;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int S   = 4;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pll_locked = 1'b0;
    logic [23:0] pix_rgb = '0;
    logic        pixel_req;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic        frame_start;
    logic        hsync_n;
    logic        vsync_n;
    logic        de;
    logic [23:0] rgb_out;
    logic        running;

    video_timing_480p #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SETTLE_CYCLES(S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_locked(pll_locked),
        .pixel_req(pixel_req),
        .req_x(req_x),
        .req_y(req_y),
        .pix_rgb(pix_rgb),
        .frame_start(frame_start),
        .hsync_n(hsync_n),
        .vsync_n(vsync_n),
        .de(de),
        .rgb_out(rgb_out),
        .running(running)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        running;
        logic        pixel_req;
        logic [9:0]  req_x;
        logic [9:0]  req_y;
        logic        frame_start;
        logic        hsync_n;
        logic        vsync_n;
        logic        de;
        logic [23:0] rgb_out;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];

    function automatic obs_t observe();
        obs_t o;
        o.running     = running;
        o.pixel_req   = pixel_req;
        o.req_x       = req_x;
        o.req_y       = req_y;
        o.frame_start = frame_start;
        o.hsync_n     = hsync_n;
        o.vsync_n     = vsync_n;
        o.de          = de;
        o.rgb_out     = rgb_out;
        return o;
    endfunction

    function automatic obs_t reset_obs();
        obs_t o;
        o         = '0;
        o.hsync_n = 1'b1;
        o.vsync_n = 1'b1;
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t got,
                             input obs_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got run=%b req=%b x=%0d y=%0d fs=%b hs=%b vs=%b de=%b rgb=%h want run=%b req=%b x=%0d y=%0d fs=%b hs=%b vs=%b de=%b rgb=%h",
                     name, $time,
                     got.running, got.pixel_req, got.req_x, got.req_y,
                     got.frame_start, got.hsync_n, got.vsync_n, got.de,
                     got.rgb_out,
                     want.running, want.pixel_req, want.req_x, want.req_y,
                     want.frame_start, want.hsync_n, want.vsync_n, want.de,
                     want.rgb_out);
        end
    endtask

    task automatic check_int(input string name, input int got,
                             input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Reference model: the block runs once locked_s (pll_locked two edges
    // late) has been seen high for S+1 consecutive edges; the raster
    // position is then simply elapsed run time modulo line/frame length.
    initial begin : model
        bit   p0, p1, ls;
        int   lk;
        int   t;
        bit   run_h[3];
        bit   act_h[3];
        int   x_h[3];
        int   y_h[3];
        obs_t e;
        p0 = 0;
        p1 = 0;
        lk = 0;
        for (int i = 0; i < 3; i++) begin
            run_h[i] = 0;
            act_h[i] = 0;
            x_h[i]   = 0;
            y_h[i]   = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                p0 = 0;
                p1 = 0;
                lk = 0;
                for (int i = 0; i < 3; i++) begin
                    run_h[i] = 0;
                    act_h[i] = 0;
                    x_h[i]   = 0;
                    y_h[i]   = 0;
                end
                exp_q.delete();
            end else begin
                ls = p1;
                p1 = p0;
                p0 = pll_locked;
                lk = ls ? lk + 1 : 0;
                for (int i = 2; i > 0; i--) begin
                    run_h[i] = run_h[i-1];
                    act_h[i] = act_h[i-1];
                    x_h[i]   = x_h[i-1];
                    y_h[i]   = y_h[i-1];
                end
                run_h[0] = (lk >= S + 1);
                t        = lk - (S + 1);
                x_h[0]   = run_h[0] ? t % HT : 0;
                y_h[0]   = run_h[0] ? (t / HT) % VT : 0;
                act_h[0] = run_h[0] && x_h[0] < HA && y_h[0] < VA;
                e.running     = run_h[0];
                e.pixel_req   = act_h[0];
                e.req_x       = act_h[0] ? 10'(x_h[0]) : 10'd0;
                e.req_y       = act_h[0] ? 10'(y_h[0]) : 10'd0;
                e.frame_start = run_h[0] && (t % FT) == 0;
                e.de          = act_h[2] && run_h[1];
                e.hsync_n     = !(run_h[2] && run_h[1] &&
                                  x_h[2] >= HA + HFP &&
                                  x_h[2] <  HA + HFP + HS);
                e.vsync_n     = !(run_h[2] && run_h[1] &&
                                  y_h[2] >= VA + VFP &&
                                  y_h[2] <  VA + VFP + VS);
                e.rgb_out     = e.de ? {8'(x_h[2]), 8'(y_h[2]), 8'hA5}
                                     : 24'd0;
                exp_q.push_back(e);
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst) begin
                check_obs("in_reset", observe(), reset_obs());
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty t=%0t got 0 entries want 1",
                         $time);
            end else begin
                check_obs("cycle", observe(), exp_q.pop_front());
            end
        end
    end

    // Framebuffer stand-in: answers each request one cycle later, and
    // drives noise whenever no request was made.
    initial begin : upstream
        bit         pv;
        logic [9:0] rx;
        logic [9:0] ry;
        pv = 0;
        rx = '0;
        ry = '0;
        forever begin
            @(negedge clk);
            pix_rgb = pv ? {rx[7:0], ry[7:0], 8'hA5} : 24'($urandom);
            pv = pixel_req;
            rx = req_x;
            ry = req_y;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure_latency(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!running && n < 50);
        check_int(name, n, S + 3);
    endtask

    task automatic wait_pos(input int x, input int y);
        int n;
        n = 0;
        while (!(pixel_req && req_x == 10'(x) && req_y == 10'(y)) &&
               n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2 * FT) begin
            checks++;
            errors++;
            $display("FAIL wait_pos timeout got none want (%0d,%0d)", x, y);
        end
    endtask

    task automatic measure_frame();
        int n;
        int clocks;
        int des;
        n = 0;
        while (!frame_start && n < 2 * FT) begin
            @(negedge clk);
            n++;
        end
        clocks = 0;
        des    = 0;
        do begin
            @(negedge clk);
            clocks++;
            if (de)
                des++;
        end while (!frame_start && clocks < 2 * FT);
        check_int("frame_clocks", clocks, FT);
        check_int("frame_de", des, HA * VA);
    endtask

    initial begin : stimulus
        wait_cycles(3);
        check_obs("reset_values", observe(), reset_obs());
        #1 rst = 1'b0;
        wait_cycles($urandom_range(3, 10));

        @(negedge clk);
        pll_locked = 1'b1;
        measure_latency("bringup_latency");
        measure_frame();
        measure_frame();

        wait_pos(12, 5);
        pll_locked = 1'b0;
        wait_cycles($urandom_range(5, 20));
        pll_locked = 1'b1;
        measure_latency("relock_latency");
        wait_cycles(40);

        pll_locked = 1'b0;
        wait_cycles(10);
        pll_locked = 1'b1;
        wait_cycles(4);
        pll_locked = 1'b0;
        wait_cycles(3);
        pll_locked = 1'b1;
        measure_latency("settle_glitch_latency");

        for (int i = 0; i < 6; i++) begin
            wait_cycles($urandom_range(20, 1200));
            pll_locked = 1'b0;
            wait_cycles($urandom_range(1, 5));
            pll_locked = 1'b1;
        end

        wait_pos(5, 3);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_obs("async_rst", observe(), reset_obs());
        wait_cycles(3);
        #1 rst = 1'b0;
        measure_latency("post_rst_latency");
        wait_cycles(FT + 60);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
